// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, through a registered carry.
// Operands arrive and results leave over valid/ready handshakes; one result per STEPS+1 clocks.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | processing one digit per clock
// DONE  | result presented, held until out_ready
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic             carry_r, ovf_r;
    logic [CNT_W-1:0] cnt;
    logic             accept, last;
    logic [DIGIT:0]   digit_sum;
    logic             msb_cin;

    assign digit_sum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_r};
    // Carry into the digit's top bit recovered from its sum bit, for the overflow tap.
    assign msb_cin   = digit_sum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
    assign last      = (cnt == CNT_W'(STEPS - 1));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry.
            op_a    <= a;
            op_b    <= sub ? ~b : b;
            carry_r <= sub ? ~cin : cin;
            res     <= '0;
            ovf_r   <= 1'b0;
            cnt     <= '0;
        end else if (state == RUN) begin
            op_a    <= op_a >> DIGIT;
            op_b    <= op_b >> DIGIT;
            res     <= (res >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
            carry_r <= digit_sum[DIGIT];
            cnt     <= cnt + CNT_W'(1);
            if (last) ovf_r <= msb_cin ^ digit_sum[DIGIT];
        end
    end

    assign sum      = res;
    assign carry    = carry_r;
    assign overflow = ovf_r;
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder/subtractor, the multi-bit sequential successor to the single-bit full adder. It accepts two WIDTH-bit operands, a carry-in and an add/sub mode through a valid/ready handshake. It processes DIGIT bits per clock LSB-first through a registered carry, and presents sum, carry-out and signed overflow through a valid/ready output handshake. It is intended for area-constrained datapaths where a WIDTH-bit ripple adder is too large.

## Interface
- WIDTH, 8: operand/result width in bits; WIDTH ≥ 2 and a multiple of DIGIT.
- DIGIT, 1: bits processed per clock; STEPS = WIDTH/DIGIT.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- carry  out  1  carry-out; in sub mode 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, sum=0, carry=0, overflow=0. Internal carry, step counter and shift registers are cleared.
- Acceptance occurs on an edge with in_valid && in_ready. The block captures a, b and sub. If sub=0, it captures cin as the initial carry. If sub=1, it captures b inverted and ~cin as the initial carry. State goes to RUN and the counter is set to 0.
- Arithmetic:
  - sub=0: {carry,sum} = a + b + cin.
  - sub=1: {carry,sum} = a + ~b + ~cin, i.e. a − b − cin, with carry = NOT borrow.
- RUN: each edge adds the low DIGIT bits of the operand shift registers plus the registered carry. The DIGIT-bit result is shifted into the result register from the MSB side, operands shift right by DIGIT, the carry register updates, and the counter increments.
- On the edge where the counter reaches STEPS−1, the final digit is processed and state goes to DONE.
- In DONE:
  - out_valid=1.
  - sum holds the full result.
  - carry holds the final carry.
  - overflow = carry into MSB XOR carry out of MSB. This is computed within the last digit, so a per-digit MSB carry tap is required when DIGIT > 1.
- sum, carry and overflow are stable throughout DONE and change only on a new acceptance or on reset.
- DONE exits on out_valid && out_ready. It goes to IDLE, or directly to RUN if a new operand set is accepted on the same edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from out_ready, giving zero-bubble back-to-back operation.
- in_valid while in RUN is ignored. Inputs a, b, cin and sub are don't-care outside the acceptance edge.

## Timing
- Latency: out_valid rises exactly STEPS clocks after the acceptance edge.
- Throughput: one result per STEPS+1 clocks with out_ready held high. If the next acceptance is on the DONE exit edge, the next result follows STEPS clocks after that edge.
- out_valid never drops without out_ready. A stalled consumer holds DONE indefinitely.
- Asynchronous reset mid-RUN or mid-DONE immediately forces IDLE and the reset values above. No partial result is emitted.
- The first edge after rst_n deasserts may accept operands.

## Test plan
- WIDTH=8, DIGIT=1, add: 0x0F+0x01, cin=0 → sum=0x10, carry=0, overflow=0. out_valid is asserted exactly 8 clocks after acceptance and is held until out_ready.
- WIDTH=8, DIGIT=1, add:
  - 0xFF+0x01, cin=0 → sum=0x00, carry=1, overflow=0.
  - 0x7F+0x00, cin=1 → sum=0x80, carry=0, overflow=1.
- WIDTH=8, DIGIT=1, sub:
  - 0x05−0x07, cin=0 → sum=0xFE, carry=0, overflow=0.
  - 0x80−0x01 → sum=0x7F, carry=1, overflow=1.
- WIDTH=8, DIGIT=4: 0xAB+0x55, cin=0 → sum=0x00, carry=1, with latency 2 clocks. Also run three back-to-back transactions with in_valid and out_ready held high: exactly one result per 3 clocks, with no loss or duplication.
- Reset mid-RUN: assert rst_n=0 after the 3rd RUN edge → outputs go to zero immediately and in_ready=1. A new transaction after release completes correctly.
- WIDTH=4, DIGIT=1, exhaustive: all 2×2×16×16 combinations of sub, cin, a and b, with randomised out_ready stalls → results match a ± b ± cin from the reference model, and out_valid is never dropped while stalled.
